instr_fetch_stage: RTL
======================

INSTR_FETCH_STAGE -- requirements
Module: instr_fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0040_0000: PC value loaded on reset.
REQ-002 SHALL have parameter IADDR_W, default 10: instruction-memory word-address width.
REQ-003 SHALL have parameter NOP_INSTR, default 32'h0000_0013: bubble encoding (addi x0,x0,0).
REQ-004 clockCPU  in  1  CPU clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 stall_i  in  1  hazard unit: hold PC and IF/ID register.
REQ-007 flush_i  in  1  squash the IF/ID entry being written this cycle.
REQ-008 redirect_i  in  1  taken branch/jump: load PC from redirect_pc_i.
REQ-009 redirect_pc_i  in  32  redirect target address.
REQ-010 imem_rdata_i  in  32  instruction word at imem_addr_o, valid within the same clockCPU cycle.
REQ-011 imem_addr_o  out  IADDR_W  instruction-memory word address.
REQ-012 pc_o  out  32  current fetch PC.
REQ-013 if_id_pc_o  out  32  PC of the instruction held in IF/ID.
REQ-014 if_id_pc4_o  out  32  if_id_pc_o + 4.
REQ-015 if_id_instr_o  out  32  instruction held in IF/ID.
REQ-016 if_id_valid_o  out  1  IF/ID holds a real instruction.
REQ-017 misalign_o  out  1  sticky flag: a redirect target had bits[1:0] != 0.
REQ-018 fetch_count_o  out  32  count of valid instructions latched into IF/ID.

Function
REQ-019 imem_addr_o SHALL equal pc_o[IADDR_W+1:2], combinationally.
REQ-020 SHALL implement a two-state FSM: BOOT, RUN.
REQ-021 BOOT: PC holds RESET_PC, IF/ID loads a bubble, next state RUN unconditionally; the one-cycle bubble covers synchronous-memory first-read latency.
REQ-022 RUN: per-edge update priority SHALL be redirect_i > stall_i > normal.
REQ-023 Normal (RUN, no redirect, no stall): PC <= PC+4; IF/ID <= {PC, PC+4, imem_rdata_i, valid=1}.
REQ-024 redirect_i=1: PC <= {redirect_pc_i[31:2], 2'b00}; IF/ID <= bubble; stall_i ignored that cycle.
REQ-025 redirect_i=1 with redirect_pc_i[1:0] != 0: misalign_o SHALL set and remain 1 until reset.
REQ-026 stall_i=1, redirect_i=0: PC and all IF/ID fields hold; fetch_count_o unchanged.
REQ-027 flush_i=1, redirect_i=0, stall_i=0: PC advances as in REQ-023, but IF/ID <= bubble.
REQ-028 flush_i=1 with stall_i=1, redirect_i=0: PC holds, IF/ID <= bubble (flush overrides hold for IF/ID only).
REQ-029 Bubble SHALL be: if_id_instr_o=NOP_INSTR, if_id_valid_o=0, if_id_pc_o=0, if_id_pc4_o=0.
REQ-030 PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 -> 32'h0000_0000, no flag.
REQ-031 fetch_count_o SHALL increment by 1 exactly on edges where IF/ID is loaded with valid=1; it wraps 32'hFFFF_FFFF -> 0.
REQ-032 if_id_pc4_o SHALL be registered, not computed from if_id_pc_o combinationally.

Reset
REQ-033 reset=1 SHALL immediately, without a clock edge, force: PC=RESET_PC, FSM=BOOT, IF/ID=bubble, misalign_o=0, fetch_count_o=0.
REQ-034 reset asserted mid-operation (including during stall or redirect) SHALL discard all in-flight state per REQ-033.
REQ-035 The first valid IF/ID entry after reset deassertion SHALL appear two rising edges later, with if_id_pc_o=RESET_PC.

Verification
REQ-036 Reset, then 4 free-running edges with imem returning word=PC -> IF/ID valid sequence 0,1,1,1; if_id_pc_o 0x00400000, 0x00400004, 0x00400008; fetch_count_o=3.
REQ-037 In RUN at PC=0x00400010, stall_i=1 for 3 edges -> pc_o and IF/ID unchanged, count unchanged; release -> PC=0x00400014.
REQ-038 redirect_i=1, redirect_pc_i=0x00400100, stall_i=1 same edge -> pc_o=0x00400100, if_id_valid_o=0, instr=0x00000013; next edge valid=1, if_id_pc_o=0x00400100.
REQ-039 redirect_pc_i=0x00400102 -> pc_o=0x00400100, misalign_o=1, still 1 after 10 further edges; cleared only by reset.
REQ-040 PC forced via redirect to 0xFFFFFFFC, one normal edge -> pc_o=0x00000000, if_id_pc4_o=0x00000000.
REQ-041 reset pulsed asynchronously between edges during stall -> outputs per REQ-033 before the next edge; REQ-035 timing holds afterwards.

Source files
------------

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: fetch PC, IF/ID pipeline register, misalignment
// flag and fetch counter. A BOOT cycle after reset inserts one bubble to
// cover the first read latency of a synchronous instruction memory.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter int unsigned IADDR_W   = 10,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic               clockCPU,
  input  logic               reset,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               redirect_i,
  input  logic [31:0]        redirect_pc_i,
  input  logic [31:0]        imem_rdata_i,
  output logic [IADDR_W-1:0] imem_addr_o,
  output logic [31:0]        pc_o,
  output logic [31:0]        if_id_pc_o,
  output logic [31:0]        if_id_pc4_o,
  output logic [31:0]        if_id_instr_o,
  output logic               if_id_valid_o,
  output logic               misalign_o,
  output logic [31:0]        fetch_count_o
);

  typedef enum logic {ST_BOOT, ST_RUN} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  localparam if_id_t BUBBLE = '{pc: 32'd0, pc4: 32'd0, instr: NOP_INSTR, valid: 1'b0};

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_pc_plus4;
  if_id_t      r_if_id;
  if_id_t      w_if_id_nxt;
  logic        r_misalign;
  logic        w_misalign_nxt;
  logic [31:0] r_fetch_count;
  logic [31:0] w_fetch_count_nxt;

  // Sequential PC + 4, wraps modulo 2^32
  assign w_pc_plus4 = r_pc + 32'd4;

  // State and datapath registers, asynchronously forced by reset
  always_ff @(posedge clockCPU or posedge reset) begin
    if (reset) begin
      r_state       <= ST_BOOT;
      r_pc          <= RESET_PC;
      r_if_id       <= BUBBLE;
      r_misalign    <= 1'b0;
      r_fetch_count <= 32'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_if_id       <= w_if_id_nxt;
      r_misalign    <= w_misalign_nxt;
      r_fetch_count <= w_fetch_count_nxt;
    end
  end

  // Next-state logic: redirect beats stall beats normal advance
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_if_id_nxt       = r_if_id;
    w_misalign_nxt    = r_misalign;
    w_fetch_count_nxt = r_fetch_count;
    case (r_state)
      ST_BOOT: begin
        w_state_nxt = ST_RUN;
        w_pc_nxt    = RESET_PC;
        w_if_id_nxt = BUBBLE;
      end
      ST_RUN: begin
        if (redirect_i) begin
          w_pc_nxt    = {redirect_pc_i[31:2], 2'b00};
          w_if_id_nxt = BUBBLE;
          if (redirect_pc_i[1:0] != 2'b00) begin
            w_misalign_nxt = 1'b1;
          end
        end else if (stall_i) begin
          // Flush still squashes the held entry; PC keeps holding
          if (flush_i) begin
            w_if_id_nxt = BUBBLE;
          end
        end else begin
          w_pc_nxt = w_pc_plus4;
          if (flush_i) begin
            w_if_id_nxt = BUBBLE;
          end else begin
            w_if_id_nxt       = '{pc: r_pc, pc4: w_pc_plus4, instr: imem_rdata_i, valid: 1'b1};
            w_fetch_count_nxt = r_fetch_count + 32'd1;
          end
        end
      end
    endcase
  end

  assign imem_addr_o   = r_pc[IADDR_W+1:2];
  assign pc_o          = r_pc;
  assign if_id_pc_o    = r_if_id.pc;
  assign if_id_pc4_o   = r_if_id.pc4;
  assign if_id_instr_o = r_if_id.instr;
  assign if_id_valid_o = r_if_id.valid;
  assign misalign_o    = r_misalign;
  assign fetch_count_o = r_fetch_count;

endmodule
